// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator, one register stage per shift-amount bit.
// Modes: SHR, ROTR, SHL, SAR; global stall on valid/ready backpressure.
module shift_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] M_SHR  = 2'b00;
  localparam logic [1:0] M_ROTR = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input int               s
  );
    logic [WIDTH-1:0] r;
    unique case (m)
      M_SHR:   r = d >> s;
      M_ROTR:  r = (d >> s) | (d << (WIDTH - s));
      M_SHL:   r = d << s;
      default: r = $unsigned($signed(d) >>> s);
    endcase
    return r;
  endfunction

  logic adv;

  // Index k is the input of stage k; index SHW is the pipe output.
  logic [WIDTH-1:0] st_data [SHW+1];
  logic [SHW-1:0]   st_amt  [SHW];
  logic [1:0]       st_mode [SHW];
  logic [SHW:0]     st_vld;

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = st_vld[SHW];
  assign out_data  = st_data[SHW];

  assign st_data[0] = in_data;
  assign st_amt[0]  = in_amt;
  assign st_mode[0] = in_mode;
  assign st_vld[0]  = in_valid;

  for (genvar k = 0; k < SHW; k++) begin : g_stg
    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (adv) begin
        vld_d  = st_vld[k];
        data_d = st_amt[k][k]
               ? step(st_data[k], st_mode[k], 1 << k)
               : st_data[k];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign st_data[k+1] = data_q;
    assign st_vld[k+1]  = vld_q;

    // The final stage has no consumer for amt/mode.
    if (k < SHW - 1) begin : g_fwd
      logic [SHW-1:0] amt_d, amt_q;
      logic [1:0]     mode_d, mode_q;

      always_comb begin
        amt_d  = amt_q;
        mode_d = mode_q;
        if (adv) begin
          amt_d  = st_amt[k];
          mode_d = st_mode[k];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q  <= '0;
          mode_q <= '0;
        end else begin
          amt_q  <= amt_d;
          mode_q <= mode_d;
        end
      end

      assign st_amt[k+1]  = amt_q;
      assign st_mode[k+1] = mode_q;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, streaming,
// backpressure, mid-flight reset and a randomized sweep vs. a reference.
module tb_shift_pipe;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_amt = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;

  shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_cyc[$];

  // Single-step reference on a double-width word.
  function automatic logic [W-1:0] ref_op(
    input logic [W-1:0] d, input int a, input logic [1:0] m);
    logic [2*W-1:0] w;
    case (m)
      2'b00:   w = {{W{1'b0}}, d} >> a;
      2'b01:   w = {d, d} >> a;
      2'b10:   w = {{W{1'b0}}, d} << a;
      default: w = {{W{d[W-1]}}, d} >> a;
    endcase
    return w[W-1:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)
        exp_q.push_back(ref_op(in_data, int'(in_amt), in_mode));
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic send_one(
    input logic [W-1:0] d, input int a, input logic [1:0] m,
    output int lat, output logic [W-1:0] res);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a[SW-1:0];
    in_mode   = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      lat = i;
      if (out_valid) begin
        res = out_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else n_pass++;
    n_chk++;
    if (out_data !== '0)
      $display("FAIL reset_out_data got=%h want=0", out_data);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [W-1:0] d_t [6];
    int           a_t [6];
    logic [1:0]   m_t [6];
    logic [W-1:0] e_t [6];
    int           lat;
    logic [W-1:0] res;
    d_t = '{32'h8000_0001, 32'h0000_00FF, 32'h0000_00FF,
            32'h0000_0001, 32'h8000_0000, 32'h4000_0000};
    a_t = '{1, 4, 0, 31, 31, 2};
    m_t = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
    e_t = '{32'h4000_0000, 32'hF000_000F, 32'h0000_00FF,
            32'h8000_0000, 32'hFFFF_FFFF, 32'h1000_0000};
    for (int i = 0; i < 6; i++) begin
      send_one(d_t[i], a_t[i], m_t[i], lat, res);
      n_chk++;
      if (lat !== 5)
        $display("FAIL directed%0d_latency got=%0d want=5", i, lat);
      else n_pass++;
      n_chk++;
      if (res !== e_t[i])
        $display("FAIL directed%0d_data got=%h want=%h", i, res, e_t[i]);
      else n_pass++;
    end
    repeat (2) @(posedge clk);
    clear_q();
  endtask

  task automatic test_back_to_back();
    clear_q();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_amt   = SW'($urandom);
      in_mode  = 2'($urandom);
      n_chk++;
      if (in_ready !== 1'b1)
        $display("FAIL b2b_in_ready beat%0d got=%b want=1", i, in_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && got_q.size() < 8; i++) @(negedge clk);
    n_chk++;
    if (got_q.size() != 8 || exp_q.size() != 8)
      $display("FAIL b2b_count got=%0d want=8", got_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (got_q[i] !== exp_q[i] || got_cyc[i] != got_cyc[0] + i)
          $display("FAIL b2b_beat%0d got=%h@%0d want=%h@%0d", i,
                   got_q[i], got_cyc[i], exp_q[i], got_cyc[0] + i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d_a [8];
    logic [W-1:0] held;
    int           idx, left;
    bit           stalled, acc;
    clear_q();
    for (int i = 0; i < 8; i++) d_a[i] = $urandom;
    idx = 0; left = 0; stalled = 0; held = '0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d_a[0];
    in_amt    = 5'd7;
    in_mode   = 2'b01;
    for (int c = 0; c < 100 && got_q.size() < 8; c++) begin
      @(negedge clk);
      if (left > 0) begin
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
          $display("FAIL stall_hold rdy=%b vld=%b data=%h want rdy=0 vld=1 data=%h",
                   in_ready, out_valid, out_data, held);
        else n_pass++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_data = d_a[idx];
        in_amt  = SW'(idx * 5);
        in_mode = 2'(idx);
      end
      if (left > 0) begin
        left--;
        if (left == 0) out_ready = 1'b1;
      end else if (!stalled && out_valid) begin
        stalled   = 1;
        left      = 3;
        out_ready = 1'b0;
        held      = out_data;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (!stalled || got_q.size() != 8 || exp_q.size() != 8)
      $display("FAIL stall_count got=%0d exp=%0d want=8", got_q.size(), exp_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL stall_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int           ovs, lat;
    logic [W-1:0] res;
    clear_q();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom | 32'h1;
      in_amt   = '0;
      in_mode  = 2'b10;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== '0)
      $display("FAIL rstmid_immediate vld=%b data=%h want vld=0 data=0",
               out_valid, out_data);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_q();
    ovs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) ovs++;
    end
    n_chk++;
    if (ovs != 0)
      $display("FAIL rstmid_no_output got=%0d valid cycles want=0", ovs);
    else n_pass++;
    send_one(32'h1234_5678, 8, 2'b01, lat, res);
    n_chk++;
    if (lat !== 5 || res !== 32'h7812_3456)
      $display("FAIL rstmid_new_beat got=%h lat=%0d want=78123456 lat=5", res, lat);
    else n_pass++;
    repeat (2) @(posedge clk);
    clear_q();
  endtask

  task automatic test_random_sweep();
    localparam int N = 160;
    int  idx, bad;
    bit  acc;
    logic [W-1:0] d_a [N];
    clear_q();
    for (int i = 0; i < N; i++) d_a[i] = $urandom;
    idx = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 3000 && !(idx == N && got_q.size() == N); c++) begin
      in_valid  = (idx < N) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      if (idx < N) begin
        in_data = d_a[idx];
        in_amt  = (idx < 128) ? SW'(idx % 32) : SW'($urandom);
        in_mode = (idx < 128) ? 2'(idx / 32) : 2'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (got_q.size() != N || exp_q.size() != N)
      $display("FAIL sweep_count got=%0d exp=%0d want=%0d",
               got_q.size(), exp_q.size(), N);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        if (bad < 10)
          $display("FAIL sweep_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
